// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and output-buffer depth.
package rtlinf_reader_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    localparam int unsigned OBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO read-side and output-stream signals of the burst reader.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_next_read;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;
    logic                  done;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_len, fifo_data, fifo_empty, m_ready,
        output cmd_ready, fifo_next_read, m_data, m_valid, m_last, done, busy
    );

    modport master (
        output cmd_valid, cmd_len, fifo_data, fifo_empty, m_ready,
        input  cmd_ready, fifo_next_read, m_data, m_valid, m_last, done, busy
    );
endinterface

// File: rtl/fifo_burst_reader_stream_out_buffer.sv
// Two-entry in-order {data, last} buffer; entry 0 is always the head so outputs come straight from flops.
module stream_out_buffer
    import rtlinf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last
);

    localparam logic [1:0] CNT_FULL = OBUF_DEPTH[1:0];

    logic [DATA_WIDTH-1:0] r_data0, r_data1, w_data0, w_data1;
    logic                  r_last0, r_last1, w_last0, w_last1;
    logic [1:0]            r_count, w_count;
    logic                  w_pop;

    assign w_pop       = i_pop && (r_count != 2'd0);
    assign o_count     = r_count;
    assign o_valid     = (r_count != 2'd0);
    assign o_head_data = r_data0;
    assign o_head_last = r_last0;

    // Next buffer contents: retire the head first, then append at the first free slot.
    always_comb begin
        w_data0 = r_data0;
        w_last0 = r_last0;
        w_data1 = r_data1;
        w_last1 = r_last1;
        w_count = r_count;
        if (w_pop) begin
            w_data0 = r_data1;
            w_last0 = r_last1;
            w_data1 = {DATA_WIDTH{1'b0}};
            w_last1 = 1'b0;
            w_count = r_count - 2'd1;
        end else begin
            w_count = r_count;
        end
        if (i_push && (w_count < CNT_FULL)) begin
            if (w_count == 2'd0) begin
                w_data0 = i_push_data;
                w_last0 = i_push_last;
            end else begin
                w_data1 = i_push_data;
                w_last1 = i_push_last;
            end
            w_count = w_count + 2'd1;
        end else begin
            w_count = w_count;
        end
    end

    // Buffer storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= {DATA_WIDTH{1'b0}};
            r_data1 <= {DATA_WIDTH{1'b0}};
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_data0 <= w_data0;
            r_data1 <= w_data1;
            r_last0 <= w_last0;
            r_last1 <= w_last1;
            r_count <= w_count;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a commanded number of FIFO entries and replays them on a registered valid/ready stream.
module fifo_burst_reader
    import rtlinf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fifo_burst_reader_if.slave  bus
);

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]           CNT_FULL = OBUF_DEPTH[1:0];

    state_e                r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_remaining, w_remaining_nxt;
    logic [1:0]            w_buf_count;
    logic                  w_buf_valid;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;
    logic                  w_pop_fifo;
    logic                  w_beat_out;

    // Pop only from registered state and the empty flag, never from m_ready.
    assign w_pop_fifo = (r_state == ST_RUN) && !bus.fifo_empty && (w_buf_count < CNT_FULL);
    assign w_beat_out = w_buf_valid && bus.m_ready;

    assign bus.fifo_next_read = w_pop_fifo;
    assign bus.cmd_ready      = (r_state == ST_IDLE);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.done           = (r_state == ST_DONE);
    assign bus.m_valid        = w_buf_valid;
    assign bus.m_data         = w_head_data;
    assign bus.m_last         = w_head_last;

    stream_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst),
        .i_push      (w_pop_fifo),
        .i_push_data (bus.fifo_data),
        .i_push_last (r_remaining == LEN_ONE),
        .i_pop       (w_beat_out),
        .o_count     (w_buf_count),
        .o_valid     (w_buf_valid),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last)
    );

    // Next-state and beat-counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_remaining_nxt = bus.cmd_len;
                    w_state_nxt     = (bus.cmd_len == LEN_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                // remaining is at least one here, so the decrement cannot wrap.
                if (w_pop_fifo) begin
                    w_remaining_nxt = r_remaining - LEN_ONE;
                    w_state_nxt     = (r_remaining == LEN_ONE) ? ST_DRAIN : ST_RUN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_beat_out && w_head_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = LEN_ZERO;
            end
        endcase
    end

    // State and beat-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= LEN_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised and directed bench for fifo_burst_reader against a transaction-level model.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 16;
    localparam int P_IDLE = 0;
    localparam int P_XFER = 1;
    localparam int P_FIN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] oq_d[$];
    bit            oq_l[$];
    int ph = P_IDLE;
    int m_len, m_popped, m_deliv;
    bit stall = 1'b0;
    bit e_pop, e_valid;
    int act_pops;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (fq.size() == 0) || stall;
        if (fq.size() != 0) bus.fifo_data = fq[0];
        else bus.fifo_data = '0;
    endtask

    task automatic fill(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++) begin
            if (rnd) fq.push_back(DW'($urandom));
            else fq.push_back(DW'(base + i));
        end
    endtask

    task automatic check_reset_outputs();
        check_value("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_value("rst_next_read", 32'(bus.fifo_next_read), 32'd0);
        check_value("rst_done", 32'(bus.done), 32'd0);
        check_value("rst_busy", 32'(bus.busy), 32'd0);
        check_value("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_value("rst_m_data", 32'(bus.m_data), 32'd0);
        check_value("rst_m_last", 32'(bus.m_last), 32'd0);
    endtask

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        drive_fifo();
        @(negedge clk);
        e_pop   = (ph == P_XFER) && (m_popped < m_len) && !bus.fifo_empty && (oq_d.size() < 2);
        e_valid = (oq_d.size() > 0);
        check_value("cmd_ready", 32'(bus.cmd_ready), 32'(ph == P_IDLE));
        check_value("busy", 32'(bus.busy), 32'(ph != P_IDLE));
        check_value("done", 32'(bus.done), 32'(ph == P_FIN));
        check_value("fifo_next_read", 32'(bus.fifo_next_read), 32'(e_pop));
        check_value("m_valid", 32'(bus.m_valid), 32'(e_valid));
        if (e_valid) begin
            check_value("m_data", 32'(bus.m_data), 32'(oq_d[0]));
            check_value("m_last", 32'(bus.m_last), 32'(oq_l[0]));
        end
        if (bus.fifo_next_read) act_pops++;
        @(posedge clk);
        #1;
        case (ph)
            P_IDLE: begin
                if (bus.cmd_valid) begin
                    m_len    = int'(bus.cmd_len);
                    m_popped = 0;
                    m_deliv  = 0;
                    ph       = (m_len == 0) ? P_FIN : P_XFER;
                end
            end
            P_XFER: begin
                if (e_valid && bus.m_ready) begin
                    void'(oq_d.pop_front());
                    void'(oq_l.pop_front());
                    m_deliv++;
                end
                if (e_pop) begin
                    oq_d.push_back(fq.pop_front());
                    oq_l.push_back(m_popped == m_len - 1);
                    m_popped++;
                end
                if (m_deliv == m_len) ph = P_FIN;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and checks outputs at once.
    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        ph = P_IDLE;
        oq_d.delete();
        oq_l.delete();
        fq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_burst(input int len, input bit rnd, input logic [31:0] rdy_mask,
                             input logic [31:0] stall_mask, input bit hold, input int abort_at);
        int  k;
        bit  aborted;
        aborted       = 1'b0;
        act_pops      = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        bus.m_ready   = rnd ? ($urandom_range(0, 3) != 0) : rdy_mask[0];
        stall         = rnd ? ($urandom_range(0, 3) == 0) : stall_mask[0];
        cycle();
        k = 1;
        while (k < 300) begin
            bus.cmd_valid = hold;
            if (hold) bus.cmd_len = LW'(5);
            if (rnd) begin
                bus.m_ready = ($urandom_range(0, 3) != 0);
                stall       = ($urandom_range(0, 3) == 0);
            end else begin
                bus.m_ready = (k < 32) ? rdy_mask[k] : 1'b1;
                stall       = (k < 32) ? stall_mask[k] : 1'b0;
            end
            if (abort_at >= 0 && ph == P_XFER && m_deliv == abort_at) begin
                mid_reset();
                aborted = 1'b1;
                break;
            end
            cycle();
            k++;
            if (ph == P_IDLE) break;
        end
        bus.cmd_valid = 1'b0;
        stall         = 1'b0;
        if (!aborted) begin
            check_value("burst_end", 32'(ph == P_IDLE), 32'd1);
            check_value("pop_count", 32'(act_pops), 32'(len));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;
        drive_fifo();
        #3;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;

        fill(4, 1'b0, 'h11);
        run_burst(4, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, -1);

        fill(4, 1'b0, 'h11);
        run_burst(4, 1'b0, 32'hFFFF_FFC7, 32'h0, 1'b0, -1);

        fill(3, 1'b1, 0);
        run_burst(3, 1'b0, 32'hFFFF_FFFF, 32'h0000_006C, 1'b0, -1);

        run_burst(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, -1);

        fill(4, 1'b1, 0);
        run_burst(4, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, -1);

        fill(8, 1'b1, 0);
        run_burst(8, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 3);
        fill(2, 1'b1, 0);
        run_burst(2, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, -1);

        for (int b = 0; b < 25; b++) begin
            len = int'($urandom_range(0, 6));
            fill(len, 1'b1, 0);
            run_burst(len, 1'b1, 32'h0, 32'h0, ($urandom_range(0, 3) == 0), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
